// File: rtl/shader_pkg.sv
// rtl/shader_pkg.sv - opcodes, FSM states and instruction field offsets for shader_fetch_decode
package shader_pkg;

   localparam logic [2:0] OP_ADD  = 3'b000;
   localparam logic [2:0] OP_MUL  = 3'b001;
   localparam logic [2:0] OP_AND  = 3'b010;
   localparam logic [2:0] OP_OR   = 3'b011;
   localparam logic [2:0] OP_NOP  = 3'b100;
   localparam logic [2:0] OP_JMP  = 3'b101;
   localparam logic [2:0] OP_HALT = 3'b110;
   localparam logic [2:0] OP_RSVD = 3'b111;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_FETCH  = 2'd1,
      ST_DECODE = 2'd2,
      ST_DRAIN  = 2'd3
   } state_e;

   // Register-index width derived from register file depth.
   function automatic int calc_rw(input int nregs);
      return $clog2(nregs);
   endfunction

   // Program counter width derived from program RAM depth.
   function automatic int calc_pcw(input int depth);
      return $clog2(depth);
   endfunction

   // Word layout, MSB first: op | mask | dest | srcA | srcB | imm.
   function automatic int calc_iw(input int lanes, input int nregs, input int depth);
      return 3 + lanes + 3 * calc_rw(nregs) + calc_pcw(depth);
   endfunction

   function automatic int off_srcb(input int depth);
      return calc_pcw(depth);
   endfunction

   function automatic int off_srca(input int nregs, input int depth);
      return calc_pcw(depth) + calc_rw(nregs);
   endfunction

   function automatic int off_dest(input int nregs, input int depth);
      return calc_pcw(depth) + 2 * calc_rw(nregs);
   endfunction

   function automatic int off_mask(input int nregs, input int depth);
      return calc_pcw(depth) + 3 * calc_rw(nregs);
   endfunction

   function automatic int off_op(input int lanes, input int nregs, input int depth);
      return calc_pcw(depth) + 3 * calc_rw(nregs) + lanes;
   endfunction

endpackage

// File: rtl/shader_prog_ram.sv
// rtl/shader_prog_ram.sv - 1W/1R synchronous program RAM with one-cycle read latency
module shader_prog_ram #(
   parameter  int WIDTH = 20,
   parameter  int DEPTH = 16,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic             re,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] rdata_q;

   // Contents are deliberately left unreset; only the loader defines them.
   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   // Registered read so the fetched word is held until the next read strobe.
   always_ff @(posedge clk) begin
      if (re) begin
         rdata_q <= mem_q[raddr];
      end
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/shader_fetch_decode.sv
// rtl/shader_fetch_decode.sv - program RAM, PC sequencer and decoded SIMD instruction output stage
module shader_fetch_decode
   import shader_pkg::*;
#(
   parameter  int LANES = 4,
   parameter  int NREGS = 8,
   parameter  int DEPTH = 16,
   localparam int RW    = calc_rw(NREGS),
   localparam int PCW   = calc_pcw(DEPTH),
   localparam int IW    = calc_iw(LANES, NREGS, DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load_en,
   input  logic [PCW-1:0]   load_addr,
   input  logic [IW-1:0]    load_data,
   input  logic             start,
   input  logic [PCW-1:0]   start_pc,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [1:0]       out_op,
   output logic [LANES-1:0] out_mask,
   output logic [RW-1:0]    out_dest,
   output logic [RW-1:0]    out_srcA,
   output logic [RW-1:0]    out_srcB,
   output logic [PCW-1:0]   out_pc
);

   localparam int OFF_SRCB = off_srcb(DEPTH);
   localparam int OFF_SRCA = off_srca(NREGS, DEPTH);
   localparam int OFF_DEST = off_dest(NREGS, DEPTH);
   localparam int OFF_MASK = off_mask(NREGS, DEPTH);
   localparam int OFF_OP   = off_op(LANES, NREGS, DEPTH);

   state_e           state_q, state_d;
   logic [PCW-1:0]   pc_q, pc_d;
   logic             err_q, err_d;
   logic             done_q, done_d;
   logic             out_valid_q, out_valid_d;
   logic [1:0]       out_op_q, out_op_d;
   logic [LANES-1:0] out_mask_q, out_mask_d;
   logic [RW-1:0]    out_dest_q, out_dest_d;
   logic [RW-1:0]    out_srca_q, out_srca_d;
   logic [RW-1:0]    out_srcb_q, out_srcb_d;
   logic [PCW-1:0]   out_pc_q, out_pc_d;

   logic [IW-1:0]    rd_word;
   logic [2:0]       op_w;
   logic [LANES-1:0] mask_w;
   logic [RW-1:0]    dest_w, srca_w, srcb_w;
   logic [PCW-1:0]   imm_w;
   logic             ram_we, ram_re, slot_free;

   // Loads are only honoured while idle so a running program is never modified.
   assign ram_we = load_en && (state_q == ST_IDLE);
   assign ram_re = (state_q == ST_FETCH);

   shader_prog_ram #(
      .WIDTH (IW),
      .DEPTH (DEPTH)
   ) u_prog_ram (
      .clk   (clk),
      .we    (ram_we),
      .waddr (load_addr),
      .wdata (load_data),
      .re    (ram_re),
      .raddr (pc_q),
      .rdata (rd_word)
   );

   assign op_w   = rd_word[OFF_OP   +: 3];
   assign mask_w = rd_word[OFF_MASK +: LANES];
   assign dest_w = rd_word[OFF_DEST +: RW];
   assign srca_w = rd_word[OFF_SRCA +: RW];
   assign srcb_w = rd_word[OFF_SRCB +: RW];
   assign imm_w  = rd_word[PCW-1:0];

   // The output slot can take a new word if empty or being drained this cycle.
   assign slot_free = !out_valid_q || out_ready;

   // Next-state, PC, status and output-slot logic.
   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      err_d       = err_q;
      done_d      = 1'b0;
      out_valid_d = out_valid_q;
      out_op_d    = out_op_q;
      out_mask_d  = out_mask_q;
      out_dest_d  = out_dest_q;
      out_srca_d  = out_srca_q;
      out_srcb_d  = out_srcb_q;
      out_pc_d    = out_pc_q;

      if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               pc_d    = start_pc;
               err_d   = 1'b0;
               state_d = ST_FETCH;
            end
         end
         ST_FETCH: begin
            state_d = ST_DECODE;
         end
         ST_DECODE: begin
            case (op_w)
               OP_ADD, OP_MUL, OP_AND, OP_OR: begin
                  // A stalled slot keeps us here; the read word stays registered.
                  if (slot_free) begin
                     out_valid_d = 1'b1;
                     out_op_d    = op_w[1:0];
                     out_mask_d  = mask_w;
                     out_dest_d  = dest_w;
                     out_srca_d  = srca_w;
                     out_srcb_d  = srcb_w;
                     out_pc_d    = pc_q;
                     pc_d        = pc_q + PCW'(1);
                     state_d     = ST_FETCH;
                  end
               end
               OP_NOP: begin
                  pc_d    = pc_q + PCW'(1);
                  state_d = ST_FETCH;
               end
               OP_JMP: begin
                  pc_d    = imm_w;
                  state_d = ST_FETCH;
               end
               OP_HALT: begin
                  state_d = ST_DRAIN;
               end
               default: begin
                  err_d   = 1'b1;
                  state_d = ST_DRAIN;
               end
            endcase
         end
         ST_DRAIN: begin
            if (slot_free) begin
               done_d  = 1'b1;
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and output registers; reset drops any pending instruction.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         pc_q        <= '0;
         err_q       <= 1'b0;
         done_q      <= 1'b0;
         out_valid_q <= 1'b0;
         out_op_q    <= '0;
         out_mask_q  <= '0;
         out_dest_q  <= '0;
         out_srca_q  <= '0;
         out_srcb_q  <= '0;
         out_pc_q    <= '0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         err_q       <= err_d;
         done_q      <= done_d;
         out_valid_q <= out_valid_d;
         out_op_q    <= out_op_d;
         out_mask_q  <= out_mask_d;
         out_dest_q  <= out_dest_d;
         out_srca_q  <= out_srca_d;
         out_srcb_q  <= out_srcb_d;
         out_pc_q    <= out_pc_d;
      end
   end

   assign busy      = (state_q != ST_IDLE);
   assign done      = done_q;
   assign err       = err_q;
   assign out_valid = out_valid_q;
   assign out_op    = out_op_q;
   assign out_mask  = out_mask_q;
   assign out_dest  = out_dest_q;
   assign out_srcA  = out_srca_q;
   assign out_srcB  = out_srcb_q;
   assign out_pc    = out_pc_q;

endmodule

// File: tb/tb_shader_fetch_decode.sv
// tb/tb_shader_fetch_decode.sv - directed self-checking bench for shader_fetch_decode
module tb_shader_fetch_decode;

   localparam int LANES = 4;
   localparam int NREGS = 8;
   localparam int DEPTH = 16;
   localparam int RW    = 3;
   localparam int PCW   = 4;
   localparam int IW    = 20;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             load_en;
   logic [PCW-1:0]   load_addr;
   logic [IW-1:0]    load_data;
   logic             start;
   logic [PCW-1:0]   start_pc;
   logic             busy, done, err, out_valid, out_ready;
   logic [1:0]       out_op;
   logic [LANES-1:0] out_mask;
   logic [RW-1:0]    out_dest, out_srcA, out_srcB;
   logic [PCW-1:0]   out_pc;

   int n_checks = 0;
   int n_errors = 0;

   logic [31:0] em_op [16];
   logic [31:0] em_mask [16];
   logic [31:0] em_dest [16];
   logic [31:0] em_srca [16];
   logic [31:0] em_srcb [16];
   logic [31:0] em_pc [16];
   int n_emit, n_done;

   always #5 clk = ~clk;

   shader_fetch_decode #(
      .LANES (LANES),
      .NREGS (NREGS),
      .DEPTH (DEPTH)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .load_en   (load_en),
      .load_addr (load_addr),
      .load_data (load_data),
      .start     (start),
      .start_pc  (start_pc),
      .busy      (busy),
      .done      (done),
      .err       (err),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_op    (out_op),
      .out_mask  (out_mask),
      .out_dest  (out_dest),
      .out_srcA  (out_srcA),
      .out_srcB  (out_srcB),
      .out_pc    (out_pc)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [IW-1:0] enc(input logic [2:0] op, input logic [3:0] m,
                                         input logic [2:0] d, input logic [2:0] a,
                                         input logic [2:0] b, input logic [3:0] imm);
      return {op, m, d, a, b, imm};
   endfunction

   task automatic load_word(input logic [PCW-1:0] addr, input logic [IW-1:0] data);
      load_addr = addr;
      load_data = data;
      load_en   = 1'b1;
      @(negedge clk);
      load_en   = 1'b0;
   endtask

   task automatic do_start(input logic [PCW-1:0] pc);
      start_pc = pc;
      start    = 1'b1;
      @(negedge clk);
      start    = 1'b0;
   endtask

   task automatic wait_valid(input int budget);
      for (int i = 0; i < budget && !out_valid; i++) @(negedge clk);
      if (!out_valid) check("timeout_valid", 32'd0, 32'd1);
   endtask

   // Records every handshake and done pulse until three cycles after the first done.
   task automatic collect(input int budget);
      int extra;
      extra  = -1;
      n_emit = 0;
      n_done = 0;
      for (int i = 0; i < budget; i++) begin
         if (out_valid && out_ready && n_emit < 16) begin
            em_op[n_emit]   = 32'(out_op);
            em_mask[n_emit] = 32'(out_mask);
            em_dest[n_emit] = 32'(out_dest);
            em_srca[n_emit] = 32'(out_srcA);
            em_srcb[n_emit] = 32'(out_srcB);
            em_pc[n_emit]   = 32'(out_pc);
            n_emit++;
         end
         if (done) begin
            n_done++;
            if (extra < 0) extra = 3;
         end
         if (extra == 0) break;
         if (extra > 0) extra--;
         @(negedge clk);
      end
      if (extra < 0) check("timeout_done", 32'd0, 32'd1);
   endtask

   initial begin
      rst_n     = 1'b0;
      load_en   = 1'b0;
      load_addr = '0;
      load_data = '0;
      start     = 1'b0;
      start_pc  = '0;
      out_ready = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_busy", 32'(busy), 0);
      check("rst_done", 32'(done), 0);
      check("rst_err", 32'(err), 0);
      check("rst_valid", 32'(out_valid), 0);
      check("rst_mask", 32'(out_mask), 0);
      check("rst_pc", 32'(out_pc), 0);
      rst_n = 1'b1;
      @(negedge clk);

      // Test 1: ADD, MUL, HALT with ready held high; start-to-valid latency.
      load_word(0, enc(3'b000, 4'hF, 3'd0, 3'd1, 3'd2, 4'd0));
      load_word(1, enc(3'b001, 4'hF, 3'd1, 3'd0, 3'd3, 4'd0));
      load_word(2, enc(3'b110, 4'h0, 3'd0, 3'd0, 3'd0, 4'd0));
      out_ready = 1'b1;
      do_start(0);
      check("t1_busy", 32'(busy), 1);
      check("t1_lat_n1", 32'(out_valid), 0);
      @(negedge clk);
      check("t1_lat_n2", 32'(out_valid), 0);
      @(negedge clk);
      check("t1_lat_n3", 32'(out_valid), 1);
      collect(60);
      check("t1_nemit", 32'(n_emit), 2);
      check("t1_op0", em_op[0], 0);
      check("t1_pc0", em_pc[0], 0);
      check("t1_mask0", em_mask[0], 'hF);
      check("t1_dest0", em_dest[0], 0);
      check("t1_srca0", em_srca[0], 1);
      check("t1_srcb0", em_srcb[0], 2);
      check("t1_op1", em_op[1], 1);
      check("t1_pc1", em_pc[1], 1);
      check("t1_dest1", em_dest[1], 1);
      check("t1_srcb1", em_srcb[1], 3);
      check("t1_ndone", 32'(n_done), 1);
      check("t1_busy_end", 32'(busy), 0);
      check("t1_err", 32'(err), 0);

      // Test 2: backpressure holds the ADD in the slot.
      out_ready = 1'b0;
      do_start(0);
      wait_valid(10);
      repeat (10) @(negedge clk);
      check("t2_valid_held", 32'(out_valid), 1);
      check("t2_op_held", 32'(out_op), 0);
      check("t2_pc_held", 32'(out_pc), 0);
      check("t2_srca_held", 32'(out_srcA), 1);
      check("t2_srcb_held", 32'(out_srcB), 2);
      check("t2_busy", 32'(busy), 1);
      out_ready = 1'b1;
      collect(60);
      check("t2_nemit", 32'(n_emit), 2);
      check("t2_op0", em_op[0], 0);
      check("t2_op1", em_op[1], 1);
      check("t2_pc1", em_pc[1], 1);
      check("t2_ndone", 32'(n_done), 1);

      // Test 3: JMP over a gap, OR, NOP, HALT.
      load_word(5, enc(3'b101, 4'h0, 3'd0, 3'd0, 3'd0, 4'd9));
      load_word(9, enc(3'b011, 4'h5, 3'd3, 3'd2, 3'd0, 4'd0));
      load_word(10, enc(3'b100, 4'h0, 3'd0, 3'd0, 3'd0, 4'd0));
      load_word(11, enc(3'b110, 4'h0, 3'd0, 3'd0, 3'd0, 4'd0));
      do_start(5);
      collect(60);
      check("t3_nemit", 32'(n_emit), 1);
      check("t3_op", em_op[0], 3);
      check("t3_mask", em_mask[0], 'h5);
      check("t3_pc", em_pc[0], 9);
      check("t3_dest", em_dest[0], 3);
      check("t3_srca", em_srca[0], 2);
      check("t3_srcb", em_srcb[0], 0);
      check("t3_ndone", 32'(n_done), 1);

      // Test 4: AND at the last address, PC wraps to a HALT at 0.
      load_word(15, enc(3'b010, 4'hC, 3'd2, 3'd3, 3'd1, 4'd0));
      load_word(0, enc(3'b110, 4'h0, 3'd0, 3'd0, 3'd0, 4'd0));
      do_start(15);
      collect(60);
      check("t4_nemit", 32'(n_emit), 1);
      check("t4_op", em_op[0], 2);
      check("t4_mask", em_mask[0], 'hC);
      check("t4_pc", em_pc[0], 15);
      check("t4_dest", em_dest[0], 2);
      check("t4_srca", em_srca[0], 3);
      check("t4_srcb", em_srcb[0], 1);
      check("t4_ndone", 32'(n_done), 1);

      // Test 5: reserved opcode sets err, next start clears it.
      load_word(3, enc(3'b111, 4'hF, 3'd7, 3'd7, 3'd7, 4'hF));
      do_start(3);
      collect(60);
      check("t5_nemit", 32'(n_emit), 0);
      check("t5_ndone", 32'(n_done), 1);
      check("t5_err", 32'(err), 1);
      check("t5_busy", 32'(busy), 0);
      do_start(0);
      check("t5_err_clr", 32'(err), 0);
      collect(60);
      check("t5_ndone2", 32'(n_done), 1);
      check("t5_err_end", 32'(err), 0);

      // Test 6a: load and start while busy are ignored.
      load_word(0, enc(3'b000, 4'hF, 3'd0, 3'd1, 3'd2, 4'd0));
      out_ready = 1'b0;
      do_start(0);
      wait_valid(10);
      load_addr = 1;
      load_data = enc(3'b011, 4'h5, 3'd3, 3'd2, 3'd0, 4'd0);
      load_en   = 1'b1;
      start_pc  = 9;
      start     = 1'b1;
      @(negedge clk);
      load_en   = 1'b0;
      start     = 1'b0;
      check("t6_pc_stable", 32'(out_pc), 0);
      out_ready = 1'b1;
      collect(60);
      check("t6_nemit", 32'(n_emit), 2);
      check("t6_op0", em_op[0], 0);
      check("t6_op1", em_op[1], 1);
      check("t6_pc1", em_pc[1], 1);
      check("t6_ndone", 32'(n_done), 1);

      // Test 6b: asynchronous reset with an instruction pending.
      out_ready = 1'b0;
      do_start(0);
      wait_valid(10);
      #2 rst_n = 1'b0;
      #1;
      check("t6_rst_valid", 32'(out_valid), 0);
      check("t6_rst_busy", 32'(busy), 0);
      check("t6_rst_done", 32'(done), 0);
      check("t6_rst_err", 32'(err), 0);
      check("t6_rst_op", 32'(out_op), 0);
      check("t6_rst_mask", 32'(out_mask), 0);
      check("t6_rst_dest", 32'(out_dest), 0);
      check("t6_rst_srca", 32'(out_srcA), 0);
      check("t6_rst_srcb", 32'(out_srcB), 0);
      check("t6_rst_pc", 32'(out_pc), 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("t6_post_busy", 32'(busy), 0);
      check("t6_post_valid", 32'(out_valid), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/shader_fetch_decode.md
Name: shader_fetch_decode

Overview:
- Parametrised successor to the fixed 16-entry shader instruction ROM/decoder.
- Holds a loadable program RAM and owns its own program counter, sequenced by a start/halt state machine.
- Supports in-program jumps and halt.
- Emits decoded SIMD ALU instructions to the lane datapath over a valid/ready handshake, and sits between the host/program loader and the SIMD register file/ALU.

Parameters:
- LANES, 4, SIMD lane count; sets mask width.
- NREGS, 8, register file depth; RW = clog2(NREGS).
- DEPTH, 16, program RAM entries (power of two); PCW = clog2(DEPTH).
- IW (localparam), 3+LANES+3*RW+PCW, instruction width (default 3+4+9+4 = 20).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- load_en  in  1  program RAM write strobe.
- load_addr  in  PCW  write address.
- load_data  in  IW  instruction word.
- start  in  1  begin execution (pulse).
- start_pc  in  PCW  entry address.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse on HALT or error.
- err  out  1  sticky: reserved opcode hit; cleared by next accepted start.
- out_valid  out  1  decoded instruction available.
- out_ready  in  1  consumer accepts.
- out_op  out  2  0=ADD, 1=MUL, 2=AND, 3=OR.
- out_mask  out  LANES  lane mask.
- out_dest  out  RW  destination register.
- out_srcA  out  RW  source A register.
- out_srcB  out  RW  source B register.
- out_pc  out  PCW  address of the emitted instruction.

Behaviour:
- Instruction layout, MSB first: op[2:0] | mask[LANES] | dest[RW] | srcA[RW] | srcB[RW] | imm[PCW].
- Opcodes:
  - 000 to 011: ALU ops (ADD, MUL, AND, OR); out_op = op[1:0].
  - 100: NOP.
  - 101: JMP to imm.
  - 110: HALT.
  - 111: reserved.
- Reset (async, rst_n=0):
  - State IDLE; pc=0.
  - busy, done, err and out_valid are 0.
  - All out_* fields are 0.
  - RAM contents are not reset.
- Program RAM:
  - Synchronous write when load_en=1 and state==IDLE; ignored otherwise.
  - Synchronous read, 1-cycle latency.
- State machine:
  - IDLE: start=1 → pc<=start_pc, err<=0, go FETCH. start while busy is ignored.
  - FETCH: issue read at pc; go DECODE.
  - DECODE: evaluate the read word.
    - ALU op, with output slot free (out_valid=0, or out_valid&out_ready this cycle): load out_* and out_pc<=pc, out_valid<=1, pc<=pc+1, go FETCH.
    - ALU op, slot full: stay in DECODE and re-evaluate the same word; no re-read.
    - NOP: pc<=pc+1, go FETCH; nothing emitted.
    - JMP: pc<=imm, go FETCH.
    - HALT: go DRAIN.
    - Reserved: err<=1, go DRAIN.
  - DRAIN: wait until out_valid=0 (or is being consumed this cycle), then pulse done and go IDLE.
- Handshake:
  - out_* fields are held stable while out_valid=1 and out_ready=0.
  - out_valid clears on out_valid&out_ready unless a new instruction is loaded in the same cycle.
- Latency: start accepted at cycle N → first out_valid at N+3. Peak throughput is 1 instruction per 2 cycles.
- pc+1 wraps from DEPTH-1 to 0; there is no end-of-memory halt.
- Simultaneous load_en and start in IDLE: the write completes and start is accepted. Execution uses the new word only if its address is read on a later cycle, which it always is.
- Reset mid-operation: immediate return to the reset state; a pending out_valid is dropped.

Decomposition:
- Package shader_pkg: opcode localparams (OP_ADD..OP_OR, OP_NOP, OP_JMP, OP_HALT, OP_RSVD), state enum, and field-offset functions of LANES/NREGS/DEPTH.
- Sub-module shader_prog_ram: parametrised 1W/1R synchronous RAM (IW × DEPTH).
- The FSM and output register stay in the top module.

Test Plan:
1. Load [0]=ADD mask 1111 d0 a1 b2, [1]=MUL mask 1111 d1 a0 b3, [2]=HALT; start_pc=0; out_ready=1 → two handshakes (op=0, pc=0), then (op=1, pc=1); done pulses once; busy=0; err=0.
2. Same program with out_ready=0 for 10 cycles after first valid → out_valid held; fields stay at the ADD values; pc does not advance. Releasing ready gives the MUL on the next transfer.
3. [5]=JMP imm=9, [9]=OR mask 0101 d3 a2 b0, [10]=NOP, [11]=HALT; start_pc=5 → single emission op=3, mask=0101, out_pc=9; done pulses.
4. DEPTH=16, [15]=AND mask 1100 d2 a3 b1, [0]=HALT; start_pc=15 → AND emitted at out_pc=15, then wrap to 0 and halt.
5. Opcode 111 at [3]; start_pc=3 → no emission; err=1 with done pulse; next start clears err.
6. Assert rst_n=0 while out_valid=1 mid-program → all outputs 0 asynchronously. load_en and start while busy are ignored, checked by RAM readback after halt.
